ov7670_sccb_init_seq: RTL

Sequences the OV7670 register configuration over SCCB by driving the command/data AXI-stream host interface of i2c_master. Walks a register ROM of {reg, value} pairs and issues one 3-phase write per entry (device address, register, value). Supports delay and end markers, and retries on missed ACK. Sits between the camera driver/HCI layer and i2c_master; reports done/error/progress for the LEDs and 7-segment display.

---
 rtl/ov7670_cfg_pkg.sv | 27 ++
 rtl/ov7670_reg_rom.sv | 66 ++++++
 rtl/ov7670_sccb_init_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_cfg_pkg.sv
// Shared types and constants for the OV7670 SCCB init sequencer and its register ROM.
package ov7670_cfg_pkg;

  localparam logic [15:0] ROM_END        = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY      = 16'hFFF0;
  localparam logic [6:0]  OV7670_WR_ADDR = 7'h21;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_CMD,
    S_DATA_REG,
    S_DATA_VAL,
    S_WAIT_BUSY_HI,
    S_WAIT_BUSY_LO,
    S_CHECK,
    S_DELAY,
    S_DONE,
    S_ERR
  } seq_state_e;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] value;
  } rom_entry_t;

endpackage

// File: rtl/ov7670_reg_rom.sv
// Registered {reg, value} ROM for the OV7670: soft reset, settle delay, RGB444 QVGA setup.
module ov7670_reg_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int IDX_W    = 7,
  parameter bit TEST_ROM = 1'b0
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output rom_entry_t       entry
);

  logic [15:0] prod_word;
  logic [15:0] test_word;

  always_comb begin
    prod_word = ROM_END;
    case (int'(addr))
      0:  prod_word = 16'h1280;
      1:  prod_word = ROM_DELAY;
      2:  prod_word = 16'h1214;
      3:  prod_word = 16'h8C02;
      4:  prod_word = 16'h0400;
      5:  prod_word = 16'h40D0;
      6:  prod_word = 16'h3A04;
      7:  prod_word = 16'h1418;
      8:  prod_word = 16'h4FB3;
      9:  prod_word = 16'h50B3;
      10: prod_word = 16'h5100;
      11: prod_word = 16'h523D;
      12: prod_word = 16'h53A7;
      13: prod_word = 16'h54E4;
      14: prod_word = 16'h589E;
      15: prod_word = 16'h3DC0;
      16: prod_word = 16'h1101;
      17: prod_word = 16'h1716;
      18: prod_word = 16'h1804;
      19: prod_word = 16'h3224;
      20: prod_word = 16'h1902;
      21: prod_word = 16'h1A7A;
      22: prod_word = 16'h030A;
      23: prod_word = 16'h0C04;
      24: prod_word = 16'h3E19;
      25: prod_word = 16'h7211;
      26: prod_word = 16'h73F1;
      27: prod_word = 16'hA202;
      default: prod_word = ROM_END;
    endcase
  end

  // Short table for simulation: reset, settle, one register, end.
  always_comb begin
    test_word = ROM_END;
    case (int'(addr))
      0: test_word = 16'h1280;
      1: test_word = ROM_DELAY;
      2: test_word = 16'h40D0;
      default: test_word = ROM_END;
    endcase
  end

  always_ff @(posedge clk) begin
    entry <= TEST_ROM ? test_word : prod_word;
  end

endmodule

// File: rtl/ov7670_sccb_init_seq.sv
// Walks the OV7670 register ROM and issues one SCCB write per entry through the
// i2c_master command/data streams, with settle delays and missed-ACK retries.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// S_IDLE         | waiting for auto-start after reset or a start pulse
// S_FETCH        | ROM read in flight (2 cycles), then decode marker/write
// S_CMD          | command beat offered until cmd handshake
// S_DATA_REG     | register byte offered until tready
// S_DATA_VAL     | value byte (tlast) offered until tready
// S_WAIT_BUSY_HI | wait for master to go busy, 16-cycle fall-through
// S_WAIT_BUSY_LO | wait for master to finish the transfer
// S_CHECK        | advance, retry on missed ACK, or give up
// S_DELAY        | settle countdown at a delay marker
// S_DONE         | sequence complete
// S_ERR          | retries exhausted, entry_idx holds the failing entry
module ov7670_sccb_init_seq
  import ov7670_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR      = OV7670_WR_ADDR,
  parameter int          NUM_ENTRIES   = 80,
  parameter logic [15:0] PRESCALE      = 16'd63,
  parameter int          SETTLE_CYCLES = 1_000_000,
  parameter int          MAX_RETRIES   = 3,
  parameter bit          AUTO_START    = 1'b1,
  parameter bit          TEST_ROM      = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic                           start,
  output logic                           done,
  output logic                           error,
  output logic                           running,
  output logic [$clog2(NUM_ENTRIES)-1:0] entry_idx,
  output logic [6:0]                     s_axis_cmd_address,
  output logic                           s_axis_cmd_start,
  output logic                           s_axis_cmd_read,
  output logic                           s_axis_cmd_write,
  output logic                           s_axis_cmd_write_multiple,
  output logic                           s_axis_cmd_stop,
  output logic                           s_axis_cmd_valid,
  input  logic                           s_axis_cmd_ready,
  output logic [7:0]                     s_axis_data_tdata,
  output logic                           s_axis_data_tvalid,
  input  logic                           s_axis_data_tready,
  output logic                           s_axis_data_tlast,
  output logic                           m_axis_data_tready,
  input  logic                           busy,
  input  logic                           missed_ack,
  output logic [15:0]                    prescale,
  output logic                           stop_on_idle
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int DLY_W = $clog2(SETTLE_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [3:0] BUSY_TMO = 4'd15;

  seq_state_e       state;
  rom_entry_t       cur;
  logic [15:0]      cur_word;
  logic             fetch_ph;
  logic             ack_err;
  logic             auto_fired;
  logic [RTY_W-1:0] retries;
  logic [DLY_W-1:0] dly_cnt;
  logic [3:0]       tmo;
  logic             launch;
  logic             ack_window;
  logic             at_end;

  ov7670_reg_rom #(
    .IDX_W    (IDX_W),
    .TEST_ROM (TEST_ROM)
  ) u_rom (
    .clk   (clk),
    .addr  (entry_idx),
    .entry (cur)
  );

  assign cur_word = cur;

  assign s_axis_cmd_address        = DEV_ADDR;
  assign s_axis_cmd_start          = s_axis_cmd_valid;
  assign s_axis_cmd_write_multiple = s_axis_cmd_valid;
  assign s_axis_cmd_stop           = s_axis_cmd_valid;
  assign s_axis_cmd_read           = 1'b0;
  assign s_axis_cmd_write          = 1'b0;
  assign m_axis_data_tready        = 1'b1;
  assign prescale                  = PRESCALE;
  assign stop_on_idle              = 1'b1;

  // A start pulse is only honoured while parked; auto-start fires once per reset.
  assign launch = (state inside {S_IDLE, S_DONE, S_ERR}) &&
                  (start || (AUTO_START && !auto_fired));

  assign ack_window = state inside {S_CMD, S_DATA_REG, S_DATA_VAL,
                                    S_WAIT_BUSY_HI, S_WAIT_BUSY_LO};

  assign at_end = ({1'b0, entry_idx} == (IDX_W + 1)'(NUM_ENTRIES));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state              <= S_IDLE;
      entry_idx          <= '0;
      retries            <= '0;
      dly_cnt            <= '0;
      tmo                <= '0;
      fetch_ph           <= 1'b0;
      ack_err            <= 1'b0;
      auto_fired         <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      running            <= 1'b0;
      s_axis_cmd_valid   <= 1'b0;
      s_axis_data_tvalid <= 1'b0;
      s_axis_data_tlast  <= 1'b0;
      s_axis_data_tdata  <= '0;
    end else begin
      if (ack_window && missed_ack) ack_err <= 1'b1;

      if (launch) begin
        state      <= S_FETCH;
        entry_idx  <= '0;
        retries    <= '0;
        fetch_ph   <= 1'b0;
        auto_fired <= 1'b1;
        done       <= 1'b0;
        error      <= 1'b0;
        running    <= 1'b1;
      end else begin
        case (state)
          S_FETCH: begin
            if (!fetch_ph) begin
              fetch_ph <= 1'b1;
            end else begin
              fetch_ph <= 1'b0;
              if (at_end || cur_word == ROM_END) begin
                state   <= S_DONE;
                done    <= 1'b1;
                running <= 1'b0;
              end else if (cur_word == ROM_DELAY) begin
                state   <= S_DELAY;
                dly_cnt <= '0;
              end else begin
                state            <= S_CMD;
                s_axis_cmd_valid <= 1'b1;
                ack_err          <= 1'b0;
              end
            end
          end
          S_CMD: begin
            if (s_axis_cmd_ready) begin
              s_axis_cmd_valid   <= 1'b0;
              s_axis_data_tvalid <= 1'b1;
              s_axis_data_tdata  <= cur.reg_addr;
              s_axis_data_tlast  <= 1'b0;
              state              <= S_DATA_REG;
            end
          end
          S_DATA_REG: begin
            if (s_axis_data_tready) begin
              s_axis_data_tdata <= cur.value;
              s_axis_data_tlast <= 1'b1;
              state             <= S_DATA_VAL;
            end
          end
          S_DATA_VAL: begin
            if (s_axis_data_tready) begin
              s_axis_data_tvalid <= 1'b0;
              s_axis_data_tlast  <= 1'b0;
              s_axis_data_tdata  <= '0;
              tmo                <= BUSY_TMO;
              state              <= S_WAIT_BUSY_HI;
            end
          end
          S_WAIT_BUSY_HI: begin
            // The master may already be idle again if the transfer was very short.
            if (busy || tmo == 4'd0) state <= S_WAIT_BUSY_LO;
            else                     tmo   <= tmo - 4'd1;
          end
          S_WAIT_BUSY_LO: begin
            if (!busy) state <= S_CHECK;
          end
          S_CHECK: begin
            if (!ack_err) begin
              entry_idx <= entry_idx + IDX_W'(1);
              retries   <= '0;
              state     <= S_FETCH;
            end else if (retries < RTY_W'(MAX_RETRIES)) begin
              retries          <= retries + RTY_W'(1);
              ack_err          <= 1'b0;
              s_axis_cmd_valid <= 1'b1;
              state            <= S_CMD;
            end else begin
              error   <= 1'b1;
              running <= 1'b0;
              state   <= S_ERR;
            end
          end
          S_DELAY: begin
            if (dly_cnt == DLY_W'(SETTLE_CYCLES - 1)) begin
              dly_cnt   <= '0;
              entry_idx <= entry_idx + IDX_W'(1);
              state     <= S_FETCH;
            end else begin
              dly_cnt <= dly_cnt + DLY_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
